// File: rtl/serial_load_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_load_pkg
// Purpose  : Shared types and constants for the serial preload controller.
//            SERIAL_LOAD_PARITY_EN adds one even-parity bit per frame.
// Revision : 1.0 - initial release
// ============================================================================
package serial_load_pkg;

  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    COMMIT   = 2'd2,
    WAIT_LOW = 2'd3
  } sl_state_t;

  function automatic int exp_bits(input int data_w);
`ifdef SERIAL_LOAD_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

  localparam int EXP_BITS_DEF = exp_bits(DATA_W_DEF);

endpackage
`default_nettype wire

// File: rtl/serial_load_ctrl_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : pin_sync
// Purpose  : Two-flop synchroniser for an asynchronous pin, with rise/fall
//            detect against a registered copy of the synchronised level.
// Revision : 1.0 - initial release
// ============================================================================
module pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = pin;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/serial_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_load_ctrl
// Purpose  : Receives a preload word over a slow serial frame (MSB first) and
//            issues a one-cycle load strobe with the word to the counter.
//            Optional macro SERIAL_LOAD_PARITY_EN: trailing even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_load_ctrl
  import serial_load_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_frame,
  input  logic              ser_clk,
  input  logic              ser_data,
  output logic              load,
  output logic [DATA_W-1:0] c_in,
  output logic              busy,
  output logic              err
);

  localparam int                EXP_BITS = exp_bits(DATA_W);
  localparam int                SH_W     = EXP_BITS;
  localparam int                CNT_W    = $clog2(DATA_W + 3);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DATA_W + 2);
  localparam logic [CNT_W-1:0]  CNT_EXP  = CNT_W'(EXP_BITS);
  localparam logic [CNT_W-1:0]  SETTLE   = CNT_W'(2);

  logic frame_s, frame_rise, frame_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic data_s, data_rise, data_fall;
  logic unused_pins;

  pin_sync u_frame_sync (.clk(clk), .rst(rst), .pin(ser_frame),
                         .level(frame_s), .rise(frame_rise), .fall(frame_fall));
  pin_sync u_sclk_sync  (.clk(clk), .rst(rst), .pin(ser_clk),
                         .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  pin_sync u_data_sync  (.clk(clk), .rst(rst), .pin(ser_data),
                         .level(data_s), .rise(data_rise), .fall(data_fall));

  assign unused_pins = ^{sclk_s, sclk_fall, data_rise, data_fall};

  sl_state_t         state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d, shift_v;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_v;
  logic              err_q, err_d;
  logic              load_q, load_d;
  logic [DATA_W-1:0] c_in_q, c_in_d;
  logic              from_commit_q, from_commit_d;
  logic              par_ok;
`ifdef SERIAL_LOAD_PARITY_EN
  logic              par_q, par_d, par_v;
`endif

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    load_d        = 1'b0;
    c_in_d        = c_in_q;
    from_commit_d = 1'b0;
    shift_v       = shreg_q;
    cnt_v         = cnt_q;
    par_ok        = 1'b1;
`ifdef SERIAL_LOAD_PARITY_EN
    par_d         = par_q;
    par_v         = par_q;
`endif

    // Capture happens before the exit check so a bit coinciding with the
    // frame fall is counted.
    if (sclk_rise) begin
      shift_v = {shreg_q[SH_W-2:0], data_s};
      if (cnt_q != CNT_MAX) cnt_v = cnt_q + CNT_W'(1);
`ifdef SERIAL_LOAD_PARITY_EN
      par_v = par_q ^ data_s;
`endif
    end
`ifdef SERIAL_LOAD_PARITY_EN
    par_ok = ~par_v;
`endif

    case (state_q)
      // The bit counter doubles as a settle timer so that reset-valued
      // synchronisers cannot make a held-high frame look low.
      WAIT_LOW: begin
        if (cnt_q != SETTLE) cnt_d = cnt_q + CNT_W'(1);
        else if (!frame_s)   state_d = IDLE;
      end
      IDLE: begin
        if (frame_rise || (from_commit_q && frame_s)) begin
          state_d = SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        shreg_d = shift_v;
        cnt_d   = cnt_v;
`ifdef SERIAL_LOAD_PARITY_EN
        par_d   = par_v;
`endif
        if (frame_fall) begin
          if ((cnt_v == CNT_EXP) && par_ok) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        c_in_d        = shreg_q[SH_W-1 -: DATA_W];
        load_d        = 1'b1;
        from_commit_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_LOW;
      shreg_q       <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      load_q        <= 1'b0;
      c_in_q        <= '0;
      from_commit_q <= 1'b0;
`ifdef SERIAL_LOAD_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      load_q        <= load_d;
      c_in_q        <= c_in_d;
      from_commit_q <= from_commit_d;
`ifdef SERIAL_LOAD_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

  assign load = load_q;
  assign c_in = c_in_q;
  assign err  = err_q;
  assign busy = (state_q == SHIFT) || (state_q == COMMIT);

endmodule
`default_nettype wire

// File: tb/tb_serial_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_load_ctrl
// Purpose  : Directed self-checking bench for serial_load_ctrl.
//            Honours SERIAL_LOAD_PARITY_EN by appending a parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_load_ctrl;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ser_frame = 1'b0;
  logic          ser_clk = 1'b0;
  logic          ser_data = 1'b0;
  logic          load;
  logic [DW-1:0] c_in;
  logic          busy;
  logic          err;

  int            n_checks = 0;
  int            n_fail = 0;
  int            load_cnt = 0;
  logic [DW-1:0] ld_val [0:31];

  int            r_first;
  logic          r_busy_pre;
  logic          r_busy_at;
  int            base;

  always #5 clk = ~clk;

  serial_load_ctrl #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ser_frame(ser_frame), .ser_clk(ser_clk),
    .ser_data(ser_data), .load(load), .c_in(c_in), .busy(busy), .err(err)
  );

  // Records every load pulse and the word presented with it.
  always @(negedge clk) begin
    if (load) begin
      if (load_cnt < 32) ld_val[load_cnt] = c_in;
      load_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic open_frame();
    ser_frame = 1'b1;
    wait_cyc(4);
  endtask

  // Shifts n bits MSB first; with coincide the last ser_clk rise drops the
  // frame at the same instant and returns with ser_clk still high.
  task automatic shift_bits(input logic [15:0] bits, input int n, input bit coincide, input bit bad_par);
    logic [16:0] vec;
    int          m;
    logic        p;
    vec = {1'b0, bits};
    m   = n;
`ifdef SERIAL_LOAD_PARITY_EN
    p = 1'b0;
    for (int i = 0; i < n; i++) p = p ^ bits[i];
    vec = {bits, p ^ bad_par};
    m   = n + 1;
`else
    p = bad_par;
`endif
    for (int i = 0; i < m; i++) begin
      ser_data = vec[m-1-i];
      wait_cyc(3);
      ser_clk = 1'b1;
      if (coincide && (i == m - 1)) begin
        ser_frame = 1'b0;
        return;
      end
      wait_cyc(3);
      ser_clk = 1'b0;
      wait_cyc(3);
    end
  endtask

  task automatic close_frame(input bit already_low);
    if (!already_low) ser_frame = 1'b0;
    r_first    = -1;
    r_busy_pre = 1'b0;
    r_busy_at  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) r_busy_pre = busy;
      if (load && (r_first < 0)) begin
        r_first   = i;
        r_busy_at = busy;
      end
    end
    ser_clk = 1'b0;
    wait_cyc(3);
  endtask

  task automatic frame(input logic [15:0] bits, input int n, input bit coincide, input bit bad_par);
    open_frame();
    shift_bits(bits, n, coincide, bad_par);
    close_frame(coincide);
  endtask

  initial begin
    wait_cyc(3);
    check_val("rst_load", 32'(load), 32'h0);
    check_val("rst_c_in", 32'(c_in), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_err",  32'(err),  32'h0);
    rst = 1'b0;
    wait_cyc(5);

    // Valid frame 1,0,1,1 with exact load timing.
    base = load_cnt;
    open_frame();
    check_val("busy_shift", 32'(busy), 32'h1);
    shift_bits(16'hB, 4, 1'b0, 1'b0);
    close_frame(1'b0);
    check_val("load_latency", 32'(r_first), 32'd3);
    check_val("busy_commit",  32'(r_busy_pre), 32'h1);
    check_val("busy_at_load", 32'(r_busy_at), 32'h0);
    check_val("ld_cnt_b", 32'(load_cnt - base), 32'd1);
    check_val("c_in_b", 32'(c_in), 32'hB);
    check_val("err_b",  32'(err),  32'h0);

    // Short frame.
    base = load_cnt;
    frame(16'h7, 3, 1'b0, 1'b0);
    check_val("ld_cnt_short", 32'(load_cnt - base), 32'd0);
    check_val("err_short",    32'(err), 32'h1);
    check_val("c_in_short",   32'(c_in), 32'hB);

    // Valid frame 0,0,1,0 clears err.
    base = load_cnt;
    frame(16'h2, 4, 1'b0, 1'b0);
    check_val("ld_cnt_2", 32'(load_cnt - base), 32'd1);
    check_val("c_in_2",   32'(c_in), 32'h2);
    check_val("err_2",    32'(err), 32'h0);

    // Long frames: 6 bits, and 12 bits which would wrap a non-saturating count.
    base = load_cnt;
    frame(16'h2D, 6, 1'b0, 1'b0);
    check_val("err_long6", 32'(err), 32'h1);
    frame(16'hABC, 12, 1'b0, 1'b0);
    check_val("err_long12", 32'(err), 32'h1);
    check_val("ld_cnt_long", 32'(load_cnt - base), 32'd0);
    check_val("c_in_long",   32'(c_in), 32'h2);

    // Reset mid-frame with the frame held high through release.
    base = load_cnt;
    open_frame();
    shift_bits(16'h2, 2, 1'b0, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(10);
    check_val("mid_busy", 32'(busy), 32'h0);
    check_val("mid_c_in", 32'(c_in), 32'h0);
    check_val("mid_err",  32'(err),  32'h0);
    for (int i = 0; i < 3; i++) begin
      ser_clk = 1'b1;
      wait_cyc(3);
      ser_clk = 1'b0;
      wait_cyc(3);
    end
    check_val("mid_busy_held", 32'(busy), 32'h0);
    ser_frame = 1'b0;
    wait_cyc(10);
    check_val("mid_ld_cnt", 32'(load_cnt - base), 32'd0);
    check_val("mid_err_drop", 32'(err), 32'h0);
    frame(16'h7, 4, 1'b0, 1'b0);
    check_val("c_in_7", 32'(c_in), 32'h7);
    check_val("ld_cnt_7", 32'(load_cnt - base), 32'd1);

    // Back-to-back frames with a one-cycle gap; second ends with a coincident bit.
    base = load_cnt;
    open_frame();
    shift_bits(16'hF, 4, 1'b0, 1'b0);
    ser_frame = 1'b0;
    tick();
    ser_frame = 1'b1;
    wait_cyc(4);
    shift_bits(16'h0, 4, 1'b1, 1'b0);
    close_frame(1'b1);
    check_val("b2b_ld_cnt", 32'(load_cnt - base), 32'd2);
    check_val("b2b_first",  32'(ld_val[base]), 32'hF);
    check_val("b2b_second", 32'(ld_val[base + 1]), 32'h0);
    check_val("coinc_latency", 32'(r_first), 32'd3);
    check_val("b2b_err", 32'(err), 32'h0);

`ifdef SERIAL_LOAD_PARITY_EN
    base = load_cnt;
    frame(16'hB, 4, 1'b0, 1'b0);
    check_val("par_good_c_in", 32'(c_in), 32'hB);
    check_val("par_good_err",  32'(err), 32'h0);
    frame(16'h4, 4, 1'b0, 1'b1);
    check_val("par_bad_err",  32'(err), 32'h1);
    check_val("par_bad_c_in", 32'(c_in), 32'hB);
    check_val("par_ld_cnt", 32'(load_cnt - base), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
